// File: rtl/exp_arbiter.sv
// Two-requester round-robin front end for a shared exponent engine. One job is in flight at a
// time; a job that outlives TIMEOUT cycles in WAIT is answered with an error response.
module exp_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_a,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_a,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_p,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_p,
  output logic        rsp1_err,

  output logic        eng_start,
  output logic [31:0] eng_x,
  output logic [31:0] eng_a,
  input  logic        eng_idle,
  input  logic        eng_done,
  input  logic [31:0] eng_p,

  output logic [15:0] jobs_done,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] x_q, x_d;
  logic [31:0] a_q, a_d;
  logic [31:0] p_q, p_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] jobs_q, jobs_d;
  logic [7:0]  errs_q, errs_d;

  logic grant;
  logic accept;
  logic rsp_fire;
  logic timeout;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept   = reset_n && (state_q == StIdle) && eng_idle && (req0_valid || req1_valid);
  assign rsp_fire = (state_q == StRespond) && (owner_q ? rsp1_ready : rsp0_ready);
  assign timeout  = (timer_q == TimerLast);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      x_q     <= '0;
      a_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
      jobs_q  <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      x_q     <= x_d;
      a_q     <= a_d;
      p_q     <= p_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      jobs_q  <= jobs_d;
      errs_q  <= errs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StIssue;
      StIssue:   state_d = StWait;
      StWait:    if (eng_done || timeout) state_d = StRespond;
      StRespond: if (rsp_fire) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    x_d     = x_q;
    a_d     = a_q;
    p_d     = p_q;
    err_d   = err_q;
    timer_d = timer_q;
    jobs_d  = jobs_q;
    errs_d  = errs_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = grant;
          last_d  = grant;
          x_d     = grant ? req1_x : req0_x;
          a_d     = grant ? req1_a : req0_a;
        end
      end
      StIssue: timer_d = '0;
      StWait: begin
        // A completion landing on the timeout cycle still counts as a normal result.
        if (eng_done) begin
          p_d   = eng_p;
          err_d = 1'b0;
        end else if (timeout) begin
          p_d   = '0;
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StRespond: begin
        if (rsp_fire) begin
          if (err_q) begin
            if (errs_q != 8'hFF) errs_d = errs_q + 8'd1;
          end else begin
            jobs_d = jobs_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Every output is forced low while reset_n is held, before the synchronous reset lands.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp0_p     = '0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_p     = '0;
    rsp1_err   = 1'b0;
    eng_start  = 1'b0;
    eng_x      = '0;
    eng_a      = '0;
    jobs_done  = '0;
    err_count  = '0;
    if (reset_n) begin
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
      eng_start  = (state_q == StIssue);
      if (state_q == StIssue || state_q == StWait) begin
        eng_x = x_q;
        eng_a = a_q;
      end
      if (state_q == StRespond) begin
        if (owner_q) begin
          rsp1_valid = 1'b1;
          rsp1_p     = p_q;
          rsp1_err   = err_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_p     = p_q;
          rsp0_err   = err_q;
        end
      end
      jobs_done = jobs_q;
      err_count = errs_q;
    end
  end

  a_ready_excl: assert property (@(posedge clock) disable iff (!reset_n)
    !(req0_ready && req1_ready));
  a_rsp_excl: assert property (@(posedge clock) disable iff (!reset_n)
    !(rsp0_valid && rsp1_valid));
  a_start_pulse: assert property (@(posedge clock) disable iff (!reset_n)
    eng_start |=> !eng_start);

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: directed scenarios plus random traffic, checked every cycle against a
// job-level model that derives response timing from acceptance time and engine latency.
module tb_exp_arbiter;

  localparam int unsigned T = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid [2];
  logic [31:0] req_x [2];
  logic [31:0] req_a [2];
  logic        rsp_ready [2];
  logic        eng_idle, eng_done;
  logic [31:0] eng_p;

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_p, rsp1_p;
  logic        eng_start;
  logic [31:0] eng_x, eng_a;
  logic [15:0] jobs_done;
  logic [7:0]  err_count;

  exp_arbiter #(.TIMEOUT(T)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req0_ready),
    .req0_x     (req_x[0]),
    .req0_a     (req_a[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req1_ready),
    .req1_x     (req_x[1]),
    .req1_a     (req_a[1]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_p     (rsp0_p),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_p     (rsp1_p),
    .rsp1_err   (rsp1_err),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_a      (eng_a),
    .eng_idle   (eng_idle),
    .eng_done   (eng_done),
    .eng_p      (eng_p),
    .jobs_done  (jobs_done),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  // Model state: at most one job outstanding, described by its key cycle numbers.
  int          cyc = 0;
  bit          busy = 0;
  int          owner = 0, last_srv = 1;
  int          start_cyc = -1, resp_cyc = -1, done_cyc = -1;
  logic [31:0] jx = 0, ja = 0, jp = 0, dres = 0;
  logic        jerr = 0;
  int          jobs_m = 0, errs_m = 0;

  // Stimulus knobs and requester queues (one pending job each).
  bit          have [2];
  logic [31:0] qx [2], qa [2], fx [2], fa [2];
  int          gen [2];
  int          lat_sel, idle_mode, rdy_mode, rst_left;
  bit          spur_en;

  // Observations of the DUT used by the directed checks.
  int          n_checks = 0, n_fail = 0;
  int          obs_gr [$];
  int          starts = 0, rdy_seen = 0, rsp_seen = 0;
  logic [31:0] start_x = 0;
  logic [31:0] last_p [2];
  logic        last_err [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pow32(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] r = 32'd1;
    logic [31:0] s = b;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = r * s;
      s = s * s;
    end
    return r;
  endfunction

  // Latency 0 means the engine never completes; T-2..T+3 straddles the timeout boundary.
  function automatic int rand_lat();
    int k = int'($urandom_range(9));
    if (k == 0) return 0;
    if (k <= 2) return int'($urandom_range(T + 3, T - 2));
    return int'($urandom_range(T, 1));
  endfunction

  task automatic drive();
    reset_n = (rst_left == 0);
    if (rst_left > 0) rst_left--;
    for (int n = 0; n < 2; n++) begin
      if (!have[n]) begin
        if (gen[n] == 2) begin
          have[n] = 1; qx[n] = fx[n]; qa[n] = fa[n];
        end else if (gen[n] == 1 && $urandom_range(1) == 1) begin
          have[n] = 1;
          qx[n] = $urandom;
          qa[n] = ($urandom_range(3) == 0) ? $urandom : $urandom_range(40);
        end
      end
      req_valid[n] = have[n];
      req_x[n] = have[n] ? qx[n] : $urandom;
      req_a[n] = have[n] ? qa[n] : $urandom;
      rsp_ready[n] = (rdy_mode == 1) || (rdy_mode == 0 && $urandom_range(1) == 1);
    end
    eng_idle = (idle_mode == 1) || (idle_mode == 0 && $urandom_range(3) != 0);
    eng_done = (cyc == done_cyc) || (spur_en && !busy && $urandom_range(7) == 0);
    eng_p    = (cyc == done_cyc) ? dres : $urandom;
  endtask

  task automatic sample();
    bit          erdy [2];
    bit          rsp_on, in_eng;
    int          win, lat, n;
    logic        obs_r [2], obs_v [2], obs_e [2];
    logic [31:0] obs_p [2];
    obs_r = '{req0_ready, req1_ready};
    obs_v = '{rsp0_valid, rsp1_valid};
    obs_e = '{rsp0_err, rsp1_err};
    obs_p = '{rsp0_p, rsp1_p};

    if (eng_start) begin starts++; start_x = eng_x; end
    if (req0_ready || req1_ready) rdy_seen++;
    if (rsp0_valid || rsp1_valid) rsp_seen++;
    for (int i = 0; i < 2; i++) begin
      if (obs_r[i] && req_valid[i]) obs_gr.push_back(i);
      if (obs_v[i] && rsp_ready[i]) begin last_p[i] = obs_p[i]; last_err[i] = obs_e[i]; end
    end

    win = (req_valid[0] && req_valid[1]) ? ((last_srv == 0) ? 1 : 0) : (req_valid[1] ? 1 : 0);
    for (int i = 0; i < 2; i++)
      erdy[i] = reset_n && !busy && eng_idle && req_valid[i] && (win == i);
    rsp_on = reset_n && busy && (cyc >= resp_cyc);
    in_eng = reset_n && busy && (cyc >= start_cyc) && (cyc < resp_cyc);

    for (int i = 0; i < 2; i++) begin
      check(i ? "ready1" : "ready0", 32'(obs_r[i]), 32'(erdy[i]));
      check(i ? "rsp1_valid" : "rsp0_valid", 32'(obs_v[i]), 32'(rsp_on && owner == i));
      check(i ? "rsp1_p" : "rsp0_p", obs_p[i], (rsp_on && owner == i) ? jp : 32'd0);
      check(i ? "rsp1_err" : "rsp0_err", 32'(obs_e[i]), 32'(rsp_on && owner == i && jerr));
    end
    check("eng_start", 32'(eng_start), 32'(reset_n && busy && cyc == start_cyc));
    check("eng_x", eng_x, in_eng ? jx : 32'd0);
    check("eng_a", eng_a, in_eng ? ja : 32'd0);
    check("jobs_done", 32'(jobs_done), reset_n ? jobs_m : 0);
    check("err_count", 32'(err_count), reset_n ? errs_m : 0);

    if (!reset_n) begin
      busy = 0; last_srv = 1; jobs_m = 0; errs_m = 0;
    end else if (rsp_on && rsp_ready[owner]) begin
      busy = 0;
      if (jerr) errs_m = (errs_m < 255) ? errs_m + 1 : 255;
      else      jobs_m = (jobs_m + 1) % 65536;
    end else if (erdy[0] || erdy[1]) begin
      n = erdy[1] ? 1 : 0;
      busy = 1; owner = n; last_srv = n; have[n] = 0;
      jx = qx[n]; ja = qa[n]; dres = pow32(jx, ja);
      start_cyc = cyc + 1;
      lat = (lat_sel >= 0) ? lat_sel : rand_lat();
      done_cyc = (lat == 0) ? -1 : start_cyc + lat;
      if (lat > 0 && lat <= int'(T)) begin
        jp = dres; jerr = 0; resp_cyc = start_cyc + lat + 1;
      end else begin
        jp = 0; jerr = 1; resp_cyc = start_cyc + int'(T) + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    drive();
    @(negedge clock);
    sample();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s0;

  initial begin
    reset_n = 1'b0;
    have = '{0, 0}; gen = '{0, 0}; qx = '{0, 0}; qa = '{0, 0}; fx = '{0, 0}; fa = '{0, 0};
    last_p = '{0, 0}; last_err = '{0, 0};
    lat_sel = -1; idle_mode = 1; rdy_mode = 1; spur_en = 0; rst_left = 3;
    run(5);

    // Single job 3^4 with a 10-cycle engine.
    have[0] = 1; qx[0] = 3; qa[0] = 4; lat_sel = 10; starts = 0;
    run(20);
    check("basic_starts", starts, 1);
    check("basic_eng_x", start_x, 3);
    check("basic_p", last_p[0], 81);
    check("basic_err", 32'(last_err[0]), 0);
    check("basic_jobs", 32'(jobs_done), 1);

    // Both requesters continuously valid: grants must alternate from requester 0.
    rst_left = 2; run(3);
    obs_gr.delete();
    fx = '{2, 5}; fa = '{5, 2}; gen = '{2, 2}; lat_sel = 3;
    run(30);
    gen = '{0, 0};
    run(20);
    check("rr_count", 32'(obs_gr.size() >= 4), 1);
    if (obs_gr.size() >= 4)
      for (int i = 0; i < 4; i++) check("rr_order", obs_gr[i], i % 2);
    check("rr_p0", last_p[0], 32);
    check("rr_p1", last_p[1], 25);

    // Engine never completes: error response after T WAIT cycles.
    rst_left = 2; run(3);
    lat_sel = 0; have[0] = 1; qx[0] = 7; qa[0] = 3; last_p[0] = 32'hFFFF_FFFF;
    run(25);
    check("tmo_err", 32'(last_err[0]), 1);
    check("tmo_p", last_p[0], 0);
    check("tmo_errcnt", 32'(err_count), 1);
    check("tmo_jobs", 32'(jobs_done), 0);

    // Response back-pressure: result held, no new grant, no launch.
    lat_sel = 3; rdy_mode = 2; have[1] = 1; qx[1] = 5; qa[1] = 2;
    run(2);
    gen[0] = 2; fx[0] = 9; fa[0] = 2;
    run(5);
    s0 = starts; rdy_seen = 0;
    run(20);
    check("hold_valid", 32'(rsp1_valid), 1);
    check("hold_p", rsp1_p, 25);
    check("hold_starts", starts - s0, 0);
    check("hold_ready", rdy_seen, 0);
    rdy_mode = 1; gen[0] = 0;
    run(20);

    // Engine busy blocks the grant; acceptance as soon as it goes idle.
    idle_mode = 2; have[0] = 1; qx[0] = 2; qa[0] = 10; lat_sel = 4; rdy_seen = 0;
    run(5);
    check("idle_blocked", rdy_seen, 0);
    idle_mode = 1;
    run(1);
    check("idle_accept", rdy_seen, 1);
    run(15);
    check("idle_p", last_p[0], 1024);

    // Reset mid-WAIT with a late completion: job is dropped, tie goes to requester 0.
    rst_left = 2; run(3);
    have[0] = 1; qx[0] = 3; qa[0] = 4; lat_sel = 10;
    run(6);
    rsp_seen = 0; rst_left = 1;
    run(13);
    check("rstw_rsp", rsp_seen, 0);
    check("rstw_jobs", 32'(jobs_done), 0);
    check("rstw_errs", 32'(err_count), 0);
    obs_gr.delete();
    fx = '{1, 1}; fa = '{1, 1}; gen = '{2, 2}; lat_sel = 2;
    run(3);
    check("rstw_first", obs_gr.size() > 0 ? obs_gr[0] : -1, 0);
    gen = '{0, 0};
    run(20);

    // Random traffic with spurious completions and timeout-boundary latencies.
    spur_en = 1; idle_mode = 0; rdy_mode = 0; gen = '{1, 1}; lat_sel = -1;
    run(3000);
    gen = '{0, 0}; rdy_mode = 1; idle_mode = 1;
    run(60);
    spur_en = 0;

    // Drive enough timeouts to saturate err_count.
    rst_left = 2; run(3);
    lat_sel = 0; gen[0] = 1;
    run(6000);
    gen[0] = 0;
    run(40);
    check("sat_errcnt", 32'(err_count), 255);
    check("sat_jobs", 32'(jobs_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
